// File: rtl/unified_mem_arbiter_if.sv
// Purpose: bundles the fetch port, load/store port and memory port of the unified memory arbiter.
// Latency: none (wiring only).
// Backpressure: requests are held by the requester until the matching gnt is seen.
interface unified_mem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_ADDR_W = 10
);
    logic                  if_req;
    logic [DATA_WIDTH-1:0] if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic                  if_err;

    logic                  d_req;
    logic                  d_we;
    logic [DATA_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic                  d_err;

    logic                  mem_en;
    logic                  mem_we;
    logic [MEM_ADDR_W-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Arbiter side: consumes requests and memory read data.
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, if_err,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    // Core/memory side: issues requests and supplies memory read data.
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Purpose: round-robin share of one sync-read word memory between fetch and load/store, with byte-to-word address translation.
// Latency: grant to rvalid is 1 cycle; one access in flight, so at most one grant every 2 cycles.
// Backpressure: requesters hold req until gnt; no grant is issued while an access is waiting for its response.
module unified_mem_arbiter #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MEM_ADDR_W = 10,
    parameter int                    TEXT_WORDS = 512,
    parameter logic [DATA_WIDTH-1:0] TEXT_BASE  = 32'h0040_0000,
    parameter logic [DATA_WIDTH-1:0] DATA_BASE  = 32'h1001_0000
) (
    input  logic clk,
    input  logic rst_n,
    unified_mem_arbiter_if.slave bus
);
    localparam int DATA_WORDS = (2 ** MEM_ADDR_W) - TEXT_WORDS;

    typedef enum logic [1:0] {IDLE, IF_WAIT, D_WAIT} state_t;

    state_t state;
    logic   last_d;   // 1 = data port won the last tie, so fetch wins the next one
    logic   err_q;    // fault flag captured at grant
    logic   we_q;     // granted access was a store (no read data to return)

    logic [DATA_WIDTH-1:0] if_off, if_word, d_off, d_word;
    logic                  if_fault, d_fault, pick_if, pick_d;

    // Offsets below base wrap to huge values and fall out of range naturally.
    assign if_off   = bus.if_addr - TEXT_BASE;
    assign if_word  = if_off >> 2;
    assign if_fault = (bus.if_addr[1:0] != 2'b00) || (if_word >= DATA_WIDTH'(TEXT_WORDS));
    assign d_off    = bus.d_addr - DATA_BASE;
    assign d_word   = d_off >> 2;
    assign d_fault  = (bus.d_addr[1:0] != 2'b00) || (d_word >= DATA_WIDTH'(DATA_WORDS));

    // On a tie, the port that did not win the previous tie goes first.
    assign pick_if = (state == IDLE) && bus.if_req && (!bus.d_req || last_d);
    assign pick_d  = (state == IDLE) && bus.d_req && !pick_if;

    assign bus.if_gnt    = pick_if;
    assign bus.d_gnt     = pick_d;
    assign bus.if_rvalid = (state == IF_WAIT);
    assign bus.d_rvalid  = (state == D_WAIT);
    assign bus.if_err    = bus.if_rvalid && err_q;
    assign bus.d_err     = bus.d_rvalid && err_q;
    assign bus.if_rdata  = (bus.if_rvalid && !err_q) ? bus.mem_rdata : '0;
    assign bus.d_rdata   = (bus.d_rvalid && !err_q && !we_q) ? bus.mem_rdata : '0;

    // Memory strobe for the grant cycle; faulted grants never touch memory.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (pick_if && !if_fault) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = if_word[MEM_ADDR_W-1:0];
        end else if (pick_d && !d_fault) begin
            bus.mem_en   = 1'b1;
            bus.mem_we   = bus.d_we;
            bus.mem_addr = MEM_ADDR_W'(TEXT_WORDS) + d_word[MEM_ADDR_W-1:0];
            if (bus.d_we) begin
                bus.mem_wdata = bus.d_wdata;
            end
        end
    end

    // Arbitration FSM: grant in IDLE, spend exactly one cycle waiting, return to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            last_d <= 1'b1;
            err_q  <= 1'b0;
            we_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.if_req && bus.d_req) begin
                        last_d <= pick_d;
                    end
                    if (pick_if) begin
                        state <= IF_WAIT;
                        err_q <= if_fault;
                        we_q  <= 1'b0;
                    end else if (pick_d) begin
                        state <= D_WAIT;
                        err_q <= d_fault;
                        we_q  <= bus.d_we;
                    end
                end
                IF_WAIT, D_WAIT: begin
                    state <= IDLE;
                    err_q <= 1'b0;
                    we_q  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Purpose: scoreboard bench for unified_mem_arbiter: reference translation, arbitration model and a word memory.
// Latency: responses are expected exactly one cycle after the grant that queued them.
// Backpressure: driver holds each request until its grant, then drops it.
module tb_unified_mem_arbiter;
    localparam logic [31:0] TEXT_BASE = 32'h0040_0000;
    localparam logic [31:0] DATA_BASE = 32'h1001_0000;

    typedef struct {
        logic        is_d;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic mon_on = 1'b0;
    logic busy = 1'b0;
    logic lg_data = 1'b1;
    exp_t sb[$];
    logic [31:0] mem [0:1023];

    unified_mem_arbiter_if #(.DATA_WIDTH(32), .MEM_ADDR_W(10)) bus ();

    unified_mem_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Word memory with one-cycle registered read.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'hA5A5_0000 ^ i;
            mem[2] <= 32'h2010_0005;
            bus.mem_rdata <= '0;
        end else if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference translation written as range tests on the byte address.
    task automatic xlate_if(input logic [31:0] a, output logic ok, output logic [9:0] idx);
        logic [31:0] w;
        ok  = (a[1:0] == 2'b00) && (a >= TEXT_BASE) && (a < TEXT_BASE + 32'd2048);
        w   = (a - TEXT_BASE) / 4;
        idx = ok ? w[9:0] : 10'd0;
    endtask

    task automatic xlate_d(input logic [31:0] a, output logic ok, output logic [9:0] idx);
        logic [31:0] w;
        ok  = (a[1:0] == 2'b00) && (a >= DATA_BASE) && (a < DATA_BASE + 32'd2048);
        w   = 32'd512 + (a - DATA_BASE) / 4;
        idx = ok ? w[9:0] : 10'd0;
    endtask

    // Cycle monitor: checks grants and memory strobes, queues expected responses, pops them on rvalid.
    task automatic monitor_step();
        logic e_if, e_d, ok;
        logic [9:0] idx;
        exp_t e;
        chk("gnt_exclusive", {31'd0, bus.if_gnt & bus.d_gnt}, 32'd0);
        if (!busy) begin
            e_if = bus.if_req && (!bus.d_req || lg_data);
            e_d  = bus.d_req && !e_if;
            chk("if_gnt", {31'd0, bus.if_gnt}, {31'd0, e_if});
            chk("d_gnt", {31'd0, bus.d_gnt}, {31'd0, e_d});
            chk("if_rvalid_idle", {31'd0, bus.if_rvalid}, 32'd0);
            chk("d_rvalid_idle", {31'd0, bus.d_rvalid}, 32'd0);
            chk("if_rdata_idle", bus.if_rdata, 32'd0);
            chk("d_rdata_idle", bus.d_rdata, 32'd0);
            if (bus.if_req && bus.d_req) lg_data = e_d;
            if (e_if) begin
                xlate_if(bus.if_addr, ok, idx);
                chk("if_mem_en", {31'd0, bus.mem_en}, {31'd0, ok});
                chk("if_mem_we", {31'd0, bus.mem_we}, 32'd0);
                chk("if_mem_addr", {22'd0, bus.mem_addr}, {22'd0, idx});
                e.is_d = 1'b0; e.err = !ok; e.rdata = ok ? mem[idx] : 32'd0;
                sb.push_back(e);
                busy = 1'b1;
            end else if (e_d) begin
                xlate_d(bus.d_addr, ok, idx);
                chk("d_mem_en", {31'd0, bus.mem_en}, {31'd0, ok});
                chk("d_mem_we", {31'd0, bus.mem_we}, {31'd0, ok & bus.d_we});
                chk("d_mem_addr", {22'd0, bus.mem_addr}, {22'd0, idx});
                chk("d_mem_wdata", bus.mem_wdata, (ok && bus.d_we) ? bus.d_wdata : 32'd0);
                e.is_d = 1'b1; e.err = !ok; e.rdata = (ok && !bus.d_we) ? mem[idx] : 32'd0;
                sb.push_back(e);
                busy = 1'b1;
            end else begin
                chk("idle_mem_en", {31'd0, bus.mem_en}, 32'd0);
                chk("idle_mem_wdata", bus.mem_wdata, 32'd0);
            end
        end else begin
            chk("wait_if_gnt", {31'd0, bus.if_gnt}, 32'd0);
            chk("wait_d_gnt", {31'd0, bus.d_gnt}, 32'd0);
            chk("wait_mem_en", {31'd0, bus.mem_en}, 32'd0);
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("if_rvalid", {31'd0, bus.if_rvalid}, {31'd0, !e.is_d});
                chk("d_rvalid", {31'd0, bus.d_rvalid}, {31'd0, e.is_d});
                if (e.is_d) begin
                    chk("d_rdata", bus.d_rdata, e.rdata);
                    chk("d_err", {31'd0, bus.d_err}, {31'd0, e.err});
                end else begin
                    chk("if_rdata", bus.if_rdata, e.rdata);
                    chk("if_err", {31'd0, bus.if_err}, {31'd0, e.err});
                end
            end
            busy = 1'b0;
        end
    endtask

    always @(negedge clk) if (mon_on) monitor_step();

    task automatic wait_gnt(input logic is_d);
        int n = 0;
        @(negedge clk);
        while (!(is_d ? bus.d_gnt : bus.if_gnt) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("gnt_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic req_if(input logic [31:0] a);
        bus.if_req = 1'b1; bus.if_addr = a;
        wait_gnt(1'b0);
        bus.if_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic req_d(input logic we, input logic [31:0] a, input logic [31:0] wd);
        bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd;
        wait_gnt(1'b1);
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_wdata = '0;
        @(posedge clk); #1;
    endtask

    initial begin
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

        // Reset state
        #22;
        chk("rst_if_gnt", {31'd0, bus.if_gnt}, 32'd0);
        chk("rst_d_gnt", {31'd0, bus.d_gnt}, 32'd0);
        chk("rst_if_rvalid", {31'd0, bus.if_rvalid}, 32'd0);
        chk("rst_d_rvalid", {31'd0, bus.d_rvalid}, 32'd0);
        chk("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
        chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        chk("rst_if_rdata", bus.if_rdata, 32'd0);
        chk("rst_d_rdata", bus.d_rdata, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mon_on = 1'b1;
        @(posedge clk); #1;

        // Fetch, store then load back, faults, boundaries
        req_if(32'h0040_0008);
        req_d(1'b1, 32'h1001_0004, 32'hDEAD_BEEF);
        req_d(1'b0, 32'h1001_0004, 32'h0);
        req_if(32'h0040_0002);
        req_if(32'h003F_FFFC);
        req_d(1'b0, 32'h1001_0800, 32'h0);
        req_d(1'b1, 32'h1000_FFFC, 32'h1234_5678);
        req_d(1'b0, 32'h1001_0006, 32'h0);
        req_if(32'h0040_07FC);
        req_d(1'b0, 32'h1001_07FC, 32'h0);
        req_d(1'b1, 32'h1001_07F8, 32'h0BAD_F00D);
        req_d(1'b0, 32'h1001_07F8, 32'h0);

        // Both ports hammering: grants must alternate, fetch first
        bus.if_req = 1'b1; bus.if_addr = 32'h0040_0010;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h1001_0004;
        @(negedge clk);
        chk("rr_first_if", {31'd0, bus.if_gnt}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            bus.if_addr = bus.if_addr + 32'd4;
        end
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        @(posedge clk); #1;
        if (busy) begin @(posedge clk); #1; end

        // Reset during D_WAIT of a load
        mon_on = 1'b0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h1001_0004;
        @(negedge clk);
        chk("t6_d_gnt", {31'd0, bus.d_gnt}, 32'd1);
        @(posedge clk); #1;
        bus.d_req = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_rvalid_in_rst", {31'd0, bus.d_rvalid}, 32'd0);
        @(negedge clk);
        chk("t6_rvalid_in_rst2", {31'd0, bus.d_rvalid}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        busy = 1'b0; lg_data = 1'b1; sb.delete();
        bus.if_req = 1'b1; bus.if_addr = 32'h0040_0000;
        bus.d_req = 1'b1; bus.d_addr = 32'h1001_0000;
        @(negedge clk);
        chk("t6_tie_if_gnt", {31'd0, bus.if_gnt}, 32'd1);
        chk("t6_tie_d_gnt", {31'd0, bus.d_gnt}, 32'd0);
        @(posedge clk); #1;
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        @(negedge clk);
        chk("t6_if_rvalid", {31'd0, bus.if_rvalid}, 32'd1);
        chk("t6_if_rdata", bus.if_rdata, 32'hA5A5_0000);
        chk("t6_d_rvalid", {31'd0, bus.d_rvalid}, 32'd0);
        @(posedge clk); #1;

        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
